// File: rtl/mul_div_unit_if.sv
// Handshake and result bus for the iterative multiply/divide unit.
// The master side issues operations and HI/LO writes; the slave side returns status and results.
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic             sign;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, sign, in1, in2, hi_we, lo_we, wdata,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, sign, in1, in2, hi_we, lo_we, wdata,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative shift-add multiplier / restoring divider with HI/LO result registers.
// One step per cycle for WIDTH cycles on operand magnitudes, then a single sign-fix cycle.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            reset,
  mul_div_unit_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DZ} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic                 dz_q, dz_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  // Working registers: acc holds {partial product, multiplier} or {remainder, quotient}
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic                 op_q, op_d;
  logic                 neg_q, neg_d;
  logic                 neg_rem_q, neg_rem_d;

  logic [WIDTH:0]       shifted;
  logic [WIDTH:0]       diff;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   prod_fix;

  function automatic logic [WIDTH-1:0] cneg_w(input logic signed [WIDTH-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] cneg_2w(input logic signed [2*WIDTH-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    b_d       = b_q;
    acc_d     = acc_q;
    op_d      = op_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;

    shifted  = acc_q[2*WIDTH-1:WIDTH-1];
    diff     = shifted - {1'b0, b_q};
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    prod_fix = cneg_2w(acc_q, neg_q);

    case (state_q)
      IDLE: begin
        if (bus.hi_we) hi_d = bus.wdata;
        if (bus.lo_we) lo_d = bus.wdata;
        if (bus.start) begin
          op_d      = bus.op;
          neg_d     = bus.sign & (bus.in1[WIDTH-1] ^ bus.in2[WIDTH-1]);
          neg_rem_d = bus.sign & bus.in1[WIDTH-1];
          b_d       = cneg_w(bus.in2, bus.sign & bus.in2[WIDTH-1]);
          acc_d     = {{WIDTH{1'b0}}, cneg_w(bus.in1, bus.sign & bus.in1[WIDTH-1])};
          cnt_d     = '0;
          dz_d      = 1'b0;
          state_d   = (bus.op && (bus.in2 == '0)) ? DZ : RUN;
        end
      end
      RUN: begin
        if (op_q) begin
          // Restoring step: keep the shifted remainder when the trial subtract borrows
          acc_d = diff[WIDTH] ? {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                              : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        if (op_q) begin
          lo_d = cneg_w(acc_q[WIDTH-1:0], neg_q);
          hi_d = cneg_w(acc_q[2*WIDTH-1:WIDTH], neg_rem_q);
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      DZ: begin
        done_d  = 1'b1;
        dz_d    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_ff @(posedge clk) begin
    b_q       <= b_d;
    acc_q     <= acc_d;
    op_q      <= op_d;
    neg_q     <= neg_d;
    neg_rem_q <= neg_rem_d;
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit at WIDTH=32: products, quotients, divide-by-zero,
// busy-time restart/write rejection and mid-operation reset.
module tb_mul_div_unit;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   n, bc, dn;

  always #5 clk = ~clk;

  mul_div_unit_if #(.WIDTH(32)) bus ();
  mul_div_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic op, input logic sgn, input logic [31:0] a, input logic [31:0] b);
    bus.op    = op;
    bus.sign  = sgn;
    bus.in1   = a;
    bus.in2   = b;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int bcnt);
    cyc  = 0;
    bcnt = 0;
    while (!bus.done && cyc < 60) begin
      if (bus.busy) bcnt++;
      step();
      cyc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.sign  = 1'b0;
    bus.in1   = '0;
    bus.in2   = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    step();
    step();
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_dz", bus.div_zero, 0);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    reset = 1'b0;
    step();

    // MULTU FFFFFFFF * 2
    launch(1'b0, 1'b0, 32'hFFFF_FFFF, 32'h2);
    wait_done(n, bc);
    chk("multu_lat", n, 33);
    chk("multu_hi", bus.hi, 32'h1);
    chk("multu_lo", bus.lo, 32'hFFFF_FFFE);

    // MULT -3 * 7 issued in the done cycle
    launch(1'b0, 1'b1, 32'hFFFF_FFFD, 32'h7);
    chk("done_pulse", bus.done, 0);
    wait_done(n, bc);
    chk("mult_lat", n, 33);
    chk("mult_busy", bc, 33);
    chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mult_lo", bus.lo, 32'hFFFF_FFEB);

    launch(1'b0, 1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFA);
    wait_done(n, bc);
    chk("mult_nn_hi", bus.hi, 32'h0);
    chk("mult_nn_lo", bus.lo, 32'h1E);

    launch(1'b1, 1'b1, 32'hFFFF_FFF9, 32'h2);
    wait_done(n, bc);
    chk("div_lat", n, 33);
    chk("div_lo", bus.lo, 32'hFFFF_FFFD);
    chk("div_hi", bus.hi, 32'hFFFF_FFFF);

    launch(1'b1, 1'b0, 32'h7, 32'h2);
    wait_done(n, bc);
    chk("divu_lo", bus.lo, 32'h3);
    chk("divu_hi", bus.hi, 32'h1);

    launch(1'b1, 1'b1, 32'h7, 32'hFFFF_FFFE);
    wait_done(n, bc);
    chk("div_negd_lo", bus.lo, 32'hFFFF_FFFD);
    chk("div_negd_hi", bus.hi, 32'h1);

    launch(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n, bc);
    chk("div_ovf_lo", bus.lo, 32'h8000_0000);
    chk("div_ovf_hi", bus.hi, 32'h0);
    chk("div_ovf_dz", bus.div_zero, 0);

    // MTHI/MTLO preset, then divide by zero
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'h1234_5678;
    step();
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    chk("mthi", bus.hi, 32'h1234_5678);
    chk("mtlo", bus.lo, 32'h1234_5678);
    launch(1'b1, 1'b0, 32'h55, 32'h0);
    chk("dz_busy", bus.busy, 1);
    wait_done(n, bc);
    chk("dz_lat", n, 1);
    chk("dz_flag", bus.div_zero, 1);
    chk("dz_hi", bus.hi, 32'h1234_5678);
    chk("dz_lo", bus.lo, 32'h1234_5678);
    step();
    chk("dz_done_drop", bus.done, 0);
    chk("dz_hold", bus.div_zero, 1);

    // MULT 6*7 with a restart and MTHI attempted at cycle 5
    launch(1'b0, 1'b1, 32'h6, 32'h7);
    chk("dz_clear", bus.div_zero, 0);
    repeat (4) step();
    bus.start = 1'b1;
    bus.op    = 1'b1;
    bus.in1   = 32'h100;
    bus.in2   = 32'h0;
    bus.hi_we = 1'b1;
    bus.wdata = 32'hDEAD_BEEF;
    step();
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    chk("busy_mthi", bus.hi, 32'h1234_5678);
    wait_done(n, bc);
    chk("restart_lat", n + 5, 33);
    chk("restart_hi", bus.hi, 32'h0);
    chk("restart_lo", bus.lo, 32'h2A);
    chk("restart_dz", bus.div_zero, 0);

    // Reset at cycle 10 of a DIV
    step();
    bus.hi_we = 1'b1;
    bus.wdata = 32'hAAAA_5555;
    step();
    bus.hi_we = 1'b0;
    launch(1'b1, 1'b0, 32'h100, 32'h7);
    repeat (9) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_hi", bus.hi, 32'h0);
    chk("midrst_lo", bus.lo, 32'h0);
    chk("midrst_done", bus.done, 0);
    dn = 0;
    repeat (40) begin
      if (bus.done) dn++;
      step();
    end
    chk("midrst_no_done", dn, 0);
    launch(1'b0, 1'b0, 32'h3, 32'h4);
    wait_done(n, bc);
    chk("post_rst_lat", n, 33);
    chk("post_rst_lo", bus.lo, 32'hC);
    chk("post_rst_hi", bus.hi, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
